// File: rtl/filter_arb_pkg.sv
// rtl/filter_arb_pkg.sv - shared types and helpers for the two-channel filter arbiter
package filter_arb_pkg;

  // Arbiter sequencing: pick a channel, offer its sample, wait for the result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  // Round-robin pick: a lone full hold wins outright, contention goes to the
  // channel that was not served last. Only meaningful when a hold is full.
  function automatic logic pick_channel(input logic full_l,
                                        input logic full_r,
                                        input logic last_grant);
    logic ch;
    if (full_l && full_r) begin
      ch = ~last_grant;
    end else if (full_l) begin
      ch = CH_L;
    end else begin
      ch = CH_R;
    end
    return ch;
  endfunction

endpackage

// File: rtl/chan_hold.sv
// rtl/chan_hold.sv - one-entry sample hold register with rts/rtr handshake
module chan_hold #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              rts,
  output logic              rtr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic              full,
  output logic [DATA_W-1:0] data_out
);

  // The hold is ready whenever it is empty; no registered delay on rtr.
  assign rtr = ~full;

  // Load on handshake; empty when the filter takes the sample. A load needs
  // the hold empty and a clear needs it full, so the two never coincide.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      full     <= 1'b0;
      data_out <= '0;
    end else if (rts && !full) begin
      full     <= 1'b1;
      data_out <= data_in;
    end else if (clr) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/filter_chan_arb.sv
// rtl/filter_chan_arb.sv - round-robin sharing of one FIR datapath between left and right audio
module filter_chan_arb
  import filter_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              l_rts,
  output logic              l_rtr,
  input  logic [DATA_W-1:0] l_aud_in,
  input  logic              r_rts,
  output logic              r_rtr,
  input  logic [DATA_W-1:0] r_aud_in,
  output logic [DATA_W-1:0] l_aud_out,
  output logic              l_vld,
  output logic [DATA_W-1:0] r_aud_out,
  output logic              r_vld,
  output logic              flt_rts,
  input  logic              flt_rtr,
  output logic [DATA_W-1:0] flt_aud_in,
  input  logic [DATA_W-1:0] flt_aud_out,
  input  logic              flt_done,
  output logic              flt_coeff_sel,
  output logic              err_timeout
);

  // Counter is cleared when WAIT is entered, so it only has to reach TIMEOUT-1.
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state;
  logic              grant;
  logic              last_grant;
  logic              next_grant;
  logic [CNT_W-1:0]  cnt;
  logic              full_l;
  logic              full_r;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic              accept;
  logic              clr_l;
  logic              clr_r;

  // The filter takes the offered sample on this edge; free the owning hold.
  assign accept     = (state == ISSUE) && flt_rtr;
  assign clr_l      = accept && (grant == CH_L);
  assign clr_r      = accept && (grant == CH_R);
  assign next_grant = pick_channel(full_l, full_r, last_grant);

  chan_hold #(.DATA_W(DATA_W)) u_hold_l (
    .clk      (clk),
    .rstb     (rstb),
    .rts      (l_rts),
    .rtr      (l_rtr),
    .data_in  (l_aud_in),
    .clr      (clr_l),
    .full     (full_l),
    .data_out (hold_l)
  );

  chan_hold #(.DATA_W(DATA_W)) u_hold_r (
    .clk      (clk),
    .rstb     (rstb),
    .rts      (r_rts),
    .rtr      (r_rtr),
    .data_in  (r_aud_in),
    .clr      (clr_r),
    .full     (full_r),
    .data_out (hold_r)
  );

  // Grant, offer, and result/abort sequencing with all outputs registered.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      grant         <= CH_L;
      last_grant    <= CH_R;
      cnt           <= '0;
      flt_rts       <= 1'b0;
      flt_aud_in    <= '0;
      flt_coeff_sel <= 1'b0;
      l_aud_out     <= '0;
      r_aud_out     <= '0;
      l_vld         <= 1'b0;
      r_vld         <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      l_vld       <= 1'b0;
      r_vld       <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (full_l || full_r) begin
            grant         <= next_grant;
            flt_coeff_sel <= next_grant;
            flt_aud_in    <= (next_grant == CH_L) ? hold_l : hold_r;
            flt_rts       <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // A stray flt_done here belongs to nothing and is ignored.
          if (flt_rtr) begin
            flt_rts <= 1'b0;
            cnt     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A result arriving on the limit cycle still counts as a result.
          if (flt_done) begin
            if (grant == CH_L) begin
              l_aud_out <= flt_aud_out;
              l_vld     <= 1'b1;
            end else begin
              r_aud_out <= flt_aud_out;
              r_vld     <= 1'b1;
            end
            last_grant <= grant;
            state      <= IDLE;
          end else if (cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            last_grant  <= grant;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_chan_arb.sv
// tb/tb_filter_chan_arb.sv - randomized self-checking bench for filter_chan_arb
module tb_filter_chan_arb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rstb;
  logic        l_rts, r_rts, flt_rtr, flt_done;
  logic [15:0] l_aud_in, r_aud_in, flt_aud_out;
  logic        l_rtr, r_rtr, l_vld, r_vld, flt_rts, flt_coeff_sel, err_timeout;
  logic [15:0] l_aud_out, r_aud_out, flt_aud_in;

  filter_chan_arb #(.DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstb(rstb),
    .l_rts(l_rts), .l_rtr(l_rtr), .l_aud_in(l_aud_in),
    .r_rts(r_rts), .r_rtr(r_rtr), .r_aud_in(r_aud_in),
    .l_aud_out(l_aud_out), .l_vld(l_vld),
    .r_aud_out(r_aud_out), .r_vld(r_vld),
    .flt_rts(flt_rts), .flt_rtr(flt_rtr), .flt_aud_in(flt_aud_in),
    .flt_aud_out(flt_aud_out), .flt_done(flt_done),
    .flt_coeff_sel(flt_coeff_sel), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus sources and filter behaviour
  logic [15:0] src_l[$];
  logic [15:0] src_r[$];
  int          f_rtr_mode = 1;
  int          f_lat_lo = 3, f_lat_hi = 3;
  int          f_drop_pct = 0;
  bit          drop_next = 0;
  bit          stray_en = 0;
  int          done_cd = -1;
  logic [15:0] res_val = '0;

  // observations of the DUT
  int          cyc = 0;
  bit          off_ch[$];
  logic [15:0] off_val[$];
  int          off_edge[$];
  int          n_lvld = 0, n_rvld = 0, n_err = 0, err_edge = 0;

  // reference model: hold occupancy, offer/busy slot, round-robin memory
  bit          m_full[2];
  logic [15:0] m_hold[2];
  bit          m_offer, m_busy, m_owner, m_last;
  int          m_age;
  bit          e_sel, e_vld[2], e_err;
  logic [15:0] e_flt_in, e_out[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, want);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0; m_hold[0] = '0; m_hold[1] = '0;
    m_offer = 0; m_busy = 0; m_owner = 0; m_last = 1; m_age = 0;
    e_sel = 0; e_vld[0] = 0; e_vld[1] = 0; e_err = 0;
    e_flt_in = '0; e_out[0] = '0; e_out[1] = '0;
  endtask

  // Compare current outputs with the model, then advance the model across
  // the coming edge using only the inputs the bench is driving.
  task automatic model_step();
    bit cap0, cap1;
    chk("l_rtr", l_rtr, !m_full[0]);
    chk("r_rtr", r_rtr, !m_full[1]);
    chk("flt_rts", flt_rts, m_offer);
    chk("flt_aud_in", flt_aud_in, e_flt_in);
    chk("flt_coeff_sel", flt_coeff_sel, e_sel);
    chk("l_vld", l_vld, e_vld[0]);
    chk("r_vld", r_vld, e_vld[1]);
    chk("err_timeout", err_timeout, e_err);
    chk("l_aud_out", l_aud_out, e_out[0]);
    chk("r_aud_out", r_aud_out, e_out[1]);

    cap0 = l_rts && !m_full[0];
    cap1 = r_rts && !m_full[1];
    e_vld[0] = 0; e_vld[1] = 0; e_err = 0;
    if (m_busy) begin
      if (flt_done) begin
        e_out[m_owner] = flt_aud_out;
        e_vld[m_owner] = 1;
        m_last = m_owner;
        m_busy = 0;
      end else if (m_age == TMO - 1) begin
        e_err = 1;
        m_last = m_owner;
        m_busy = 0;
      end else begin
        m_age++;
      end
    end else if (m_offer) begin
      if (flt_rtr) begin
        m_full[m_owner] = 0;
        m_offer = 0;
        m_busy = 1;
        m_age = 0;
      end
    end else if (m_full[0] || m_full[1]) begin
      m_owner = (m_full[0] && m_full[1]) ? !m_last : m_full[1];
      m_offer = 1;
      e_sel = m_owner;
      e_flt_in = m_hold[m_owner];
    end
    if (cap0) begin m_full[0] = 1; m_hold[0] = l_aud_in; end
    if (cap1) begin m_full[1] = 1; m_hold[1] = r_aud_in; end
  endtask

  // Drive all inputs for the current cycle (called just after a rising edge).
  task automatic drive();
    l_rts    = src_l.size() > 0;
    l_aud_in = l_rts ? src_l[0] : 16'($urandom);
    r_rts    = src_r.size() > 0;
    r_aud_in = r_rts ? src_r[0] : 16'($urandom);
    case (f_rtr_mode)
      0:       flt_rtr = 1'b0;
      1:       flt_rtr = 1'b1;
      default: flt_rtr = ($urandom_range(0, 9) < 7);
    endcase
    flt_done    = 1'b0;
    flt_aud_out = 16'($urandom);
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        flt_done    = 1'b1;
        flt_aud_out = res_val;
      end
    end else if (stray_en && $urandom_range(0, 19) == 0) begin
      flt_done = 1'b1;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_step();
    if (l_rts && l_rtr) void'(src_l.pop_front());
    if (r_rts && r_rtr) void'(src_r.pop_front());
    if (flt_rts && flt_rtr) begin
      off_ch.push_back(flt_coeff_sel);
      off_val.push_back(flt_aud_in);
      off_edge.push_back(cyc + 1);
      res_val = {flt_aud_in[13:0], 2'b00};
      if (drop_next || (f_drop_pct > 0 && $urandom_range(0, 99) < f_drop_pct))
        done_cd = -1;
      else
        done_cd = $urandom_range(f_lat_lo, f_lat_hi);
      drop_next = 0;
    end
    if (l_vld) n_lvld++;
    if (r_vld) n_rvld++;
    if (err_timeout) begin n_err++; err_edge = cyc; end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int b, bl, br, be, wait_cnt;
    rstb = 1'b0;
    l_rts = 0; r_rts = 0; flt_rtr = 0; flt_done = 0;
    l_aud_in = '0; r_aud_in = '0; flt_aud_out = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;

    // reset state
    chk("rst_l_rtr", l_rtr, 1);
    chk("rst_r_rtr", r_rtr, 1);
    chk("rst_flt_rts", flt_rts, 0);
    chk("rst_sel", flt_coeff_sel, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_flt_in", flt_aud_in, 0);

    // left only, filter returns 4<<2 = 0x0010 five cycles after accept
    f_rtr_mode = 1; f_lat_lo = 5; f_lat_hi = 5;
    b = off_ch.size(); bl = n_lvld; br = n_rvld;
    src_l.push_back(16'h0004);
    wait_cnt = 0;
    while (n_lvld == bl && wait_cnt < 40) begin step(); wait_cnt++; end
    chk("t1_vld_seen", (n_lvld != bl), 1);
    steps(4);
    chk("t1_sel", off_ch[b], 0);
    chk("t1_offer", off_val[b], 16'h0004);
    chk("t1_l_out", l_aud_out, 16'h0010);
    chk("t1_l_vld_cycles", n_lvld - bl, 1);
    chk("t1_r_vld_cycles", n_rvld - br, 0);

    // contention right after reset: left first
    rstb = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #1; rstb = 1'b1;
    b = off_ch.size();
    src_l.push_back(16'd9); src_r.push_back(16'd12);
    f_lat_lo = 2; f_lat_hi = 2;
    steps(20);
    chk("t2_first_ch", off_ch[b], 0);
    chk("t2_first_val", off_val[b], 9);
    chk("t2_second_ch", off_ch[b + 1], 1);
    chk("t2_second_val", off_val[b + 1], 12);

    // sustained contention: strict alternation
    f_lat_lo = 1; f_lat_hi = 6;
    b = off_ch.size(); bl = n_lvld; br = n_rvld;
    for (int i = 1; i <= 8; i++) begin
      src_l.push_back(16'(i)); src_r.push_back(16'(i));
    end
    wait_cnt = 0;
    while ((n_lvld - bl < 8 || n_rvld - br < 8) && wait_cnt < 300) begin
      step(); wait_cnt++;
    end
    chk("t3_all_done", (n_lvld - bl == 8) && (n_rvld - br == 8), 1);
    for (int i = 0; i < 16; i++) begin
      chk("t3_grant_ch", off_ch[b + i], 32'(i % 2));
      chk("t3_grant_val", off_val[b + i], 32'(i / 2 + 1));
    end
    chk("t3_l_last", l_aud_out, 16'h0020);
    chk("t3_r_last", r_aud_out, 16'h0020);

    // backpressure in ISSUE
    steps(4);
    f_rtr_mode = 0; f_lat_lo = 3; f_lat_hi = 3;
    be = n_err; bl = n_lvld;
    src_l.push_back(16'h0123);
    steps(2);
    steps(20);
    chk("t4_flt_rts", flt_rts, 1);
    chk("t4_flt_in", flt_aud_in, 16'h0123);
    chk("t4_l_rtr", l_rtr, 0);
    chk("t4_no_err", n_err - be, 0);
    f_rtr_mode = 1;
    steps(10);
    chk("t4_l_vld", n_lvld - bl, 1);
    chk("t4_l_out", l_aud_out, 16'h048C);

    // timeout with a right sample waiting behind it
    b = off_ch.size(); bl = n_lvld; br = n_rvld; be = n_err;
    drop_next = 1;
    src_l.push_back(16'h0055);
    step();
    src_r.push_back(16'h0066);
    steps(30);
    chk("t5_err_count", n_err - be, 1);
    chk("t5_err_delay", err_edge - off_edge[b], TMO);
    chk("t5_l_vld", n_lvld - bl, 0);
    chk("t5_next_ch", off_ch[b + 1], 1);
    chk("t5_next_val", off_val[b + 1], 16'h0066);
    chk("t5_r_vld", n_rvld - br, 1);
    chk("t5_r_out", r_aud_out, 16'h0198);

    // result on the limit cycle beats the timeout
    f_lat_lo = TMO; f_lat_hi = TMO;
    bl = n_lvld; be = n_err;
    src_l.push_back(16'h0007);
    steps(20);
    chk("t5b_no_err", n_err - be, 0);
    chk("t5b_l_vld", n_lvld - bl, 1);
    chk("t5b_l_out", l_aud_out, 16'h001C);

    // asynchronous reset while waiting on the filter
    f_lat_lo = 7; f_lat_hi = 7;
    src_l.push_back(16'h0ABC);
    steps(5);
    #2;
    rstb = 1'b0;
    #1;
    chk("t6_flt_rts", flt_rts, 0);
    chk("t6_flt_in", flt_aud_in, 0);
    chk("t6_sel", flt_coeff_sel, 0);
    chk("t6_l_out", l_aud_out, 0);
    chk("t6_r_out", r_aud_out, 0);
    chk("t6_l_rtr", l_rtr, 1);
    chk("t6_vld_err", {l_vld, r_vld, err_timeout}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    bl = n_lvld;
    done_cd = 2; res_val = 16'hBEEF;
    steps(8);
    chk("t6_stray_ignored", n_lvld - bl, 0);
    chk("t6_l_out_after", l_aud_out, 0);

    // randomized traffic, filter stalls, drops and stray completions
    f_rtr_mode = 2; f_lat_lo = 1; f_lat_hi = 10; f_drop_pct = 10; stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (src_l.size() < 2 && $urandom_range(0, 99) < 30) src_l.push_back(16'($urandom));
      if (src_r.size() < 2 && $urandom_range(0, 99) < 30) src_r.push_back(16'($urandom));
      step();
    end
    f_rtr_mode = 1; f_lat_lo = 2; f_lat_hi = 2; f_drop_pct = 0; stray_en = 0;
    steps(80);
    chk("drain_l", src_l.size(), 0);
    chk("drain_r", src_r.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_chan_arb.md
# filter_chan_arb

Two-channel arbiter that time-shares the single `filter_stm` FIR datapath between left and right audio streams. Each channel hands over one 16-bit sample on an `rts`/`rtr` handshake. The block schedules samples into the filter round-robin and selects that channel's coefficient bank. It routes the filter result back to the originating channel and recovers from a filter that never completes.

## Interface
Parameters:
- `DATA_W`, 16, audio sample width.
- `TIMEOUT`, 255, cycles allowed in WAIT before abort; legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `l_rts`  in  1  left source has a sample.
- `l_rtr`  out  1  left holding register empty.
- `l_aud_in`  in  DATA_W  left sample.
- `r_rts`, `r_rtr`, `r_aud_in`: same as the left ports, for the right channel.
- `l_aud_out`  out  DATA_W  left filtered result.
- `l_vld`  out  1  one-cycle pulse: `l_aud_out` valid.
- `r_aud_out`, `r_vld`: same as the left ports, for the right channel.
- `flt_rts`  out  1  sample offered to filter.
- `flt_rtr`  in  1  filter accepts sample.
- `flt_aud_in`  out  DATA_W  sample to filter.
- `flt_aud_out`  in  DATA_W  filter result.
- `flt_done`  in  1  one-cycle pulse: `flt_aud_out` valid.
- `flt_coeff_sel`  out  1  coefficient bank: 0 = left, 1 = right.
- `err_timeout`  out  1  one-cycle pulse on abort.

## Operation
- **Handshake.** A transfer occurs on an edge where `rts` and `rtr` are both high. The same rule applies on the channel side and on the filter side.
- **Channel holds.**
  - Each channel has a one-entry hold register with a `full` flag.
  - `x_rtr = ~full_x`, driven combinationally.
  - A transfer loads the sample and sets `full`.
  - `full` clears on the edge the sample is accepted by the filter.
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE.**
  - If no hold is full, stay in IDLE.
  - If exactly one hold is full, grant that channel.
  - If both are full, grant the channel opposite `last_grant`.
  - On grant: register `grant`, set `flt_coeff_sel = grant`, go to ISSUE.
- **ISSUE.**
  - `flt_rts = 1` and `flt_aud_in = hold[grant]`.
  - When `flt_rtr` is high, clear `full[grant]` and go to WAIT. The timeout counter clears on this edge.
  - ISSUE waits indefinitely for `flt_rtr`.
- **WAIT.**
  - The counter increments each cycle.
  - On `flt_done`: register `flt_aud_out` into `x_aud_out[grant]`, pulse `x_vld[grant]` for one cycle, set `last_grant = grant`, go to IDLE.
  - If `flt_done` is absent and the counter equals `TIMEOUT - 1`: pulse `err_timeout`, set `last_grant = grant`, go to IDLE. No `vld` is issued; the sample is dropped.
- **Stray `flt_done`.** A `flt_done` arriving in IDLE or ISSUE is ignored.
- **Coefficient select.** `flt_coeff_sel` is held constant from entry to ISSUE until the next grant.
- **Arithmetic.**
  - The counter is `$clog2(TIMEOUT+1)` bits and never wraps, because it is cleared on entry to WAIT.
  - Samples and results pass through unmodified, with no width change.

## Timing
- **Reset values (asynchronous):**
  - FSM = IDLE; `full_l = full_r = 0`, so `l_rtr = r_rtr = 1`.
  - `last_grant = 1` (right), so left wins the first contention.
  - `flt_rts`, `l_vld`, `r_vld`, `err_timeout`, `flt_coeff_sel` = 0.
  - `flt_aud_in`, `l_aud_out`, `r_aud_out` = 0; the counter = 0.
- **Latency.**
  - Capture at edge t0; ISSUE entered at t1; `flt_rts` is high during cycle t1..t2.
  - With `flt_rtr` high, WAIT is entered at t2.
  - `flt_done` sampled at edge tk gives `x_vld` high for cycle tk..tk+1.
  - Minimum capture-to-`vld` is 3 edges, plus filter latency.
- **Throughput.**
  - A channel's `rtr` reasserts the cycle after its sample enters the filter, so the next sample can be held while the previous one is being filtered.
  - Capture into a hold and filter acceptance from that hold can never occur on the same edge.
- **Simultaneous events.**
  - Both channels transferring on the same edge: both holds load.
  - `flt_done` on the same edge the counter hits its limit: `flt_done` wins, with no `err_timeout`.
- **Reset mid-operation:** an in-flight sample is discarded, and all outputs return to their reset values immediately.

## Structure
- Package `filter_arb_pkg` holds:
  - the state enum: IDLE, ISSUE, WAIT;
  - the constants `CH_L = 1'b0` and `CH_R = 1'b1`.
- Sub-module `chan_hold`:
  - a one-entry hold register with `full` flag, `rts`/`rtr` handshake, and a `clr` input;
  - instantiated once per channel.
- FSM, round-robin logic, timeout counter and output registers live in the top level.

## Test plan
1. **Left only.** `l_rts` pulse with `l_aud_in = 0x0004`, `flt_rtr = 1`, filter model returns `0x0010` 5 cycles after accept. Required: `flt_coeff_sel = 0`, `l_aud_out = 0x0010`, one-cycle `l_vld`, `r_vld` never high.
2. **Contention after reset.** L = 9 and R = 12 captured on the same edge. Required: L issued first with `flt_coeff_sel = 0`, then R with `flt_coeff_sel = 1`.
3. **Sustained contention.** Both channels stream 8 samples each (values 1..8). Required: the grant sequence alternates exactly L,R,L,R,…, and each result returns on its own channel.
4. **Backpressure.** `flt_rtr = 0` for 20 cycles while in ISSUE. Required:
   - `flt_rts` stays high with `flt_aud_in` stable;
   - `l_rtr` stays low;
   - no timeout occurs.
5. **Timeout.** `TIMEOUT = 8`, `flt_done` never asserted. Required:
   - `err_timeout` pulses exactly 8 cycles after entering WAIT;
   - no `vld` is issued;
   - the next pending sample is issued.
6. **Async reset mid-WAIT.** `rstb` low for 2 cycles. Required: all outputs immediately return to their reset values, and a subsequent `flt_done` is ignored.
